// File: rtl/high_score_keeper.sv
// rtl/high_score_keeper.sv - per-user high-score table with global best tracking
// Loads the logged-in user's record on login and commits new records on game_over.
module high_score_keeper #(
  parameter int NUM_USERS = 6,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  input  logic [2:0]         user_ID,
  input  logic               game_over,
  input  logic [SCORE_W-1:0] score,
  input  logic               clear_scores,
  output logic [SCORE_W-1:0] user_high_score,
  output logic [SCORE_W-1:0] best_score,
  output logic [2:0]         best_user,
  output logic               new_record,
  output logic               busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_READY = 3'd2;
  localparam logic [2:0] S_CMP   = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0]         state;
  logic [2:0]         cur_user;
  logic [SCORE_W-1:0] cur_score;
  logic [SCORE_W-1:0] uhs_q;
  logic               rec;
  logic [SCORE_W-1:0] score_tbl [NUM_USERS];

  logic [SCORE_W-1:0] stored;
  logic               user_valid;

  // Explicit match loop so out-of-range user IDs never index the table and read as 0.
  always_comb begin
    stored     = '0;
    user_valid = 1'b0;
    for (int i = 0; i < NUM_USERS; i++) begin
      if (cur_user == 3'(i)) begin
        stored     = score_tbl[i];
        user_valid = 1'b1;
      end
    end
  end

  // The displayed value is forced to 0 until the freshly loaded entry is in uhs_q.
  assign user_high_score = (state == S_IDLE || state == S_LOAD) ? '0 : uhs_q;
  assign busy            = (state == S_CMP) || (state == S_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cur_user   <= '0;
      cur_score  <= '0;
      uhs_q      <= '0;
      rec        <= 1'b0;
      best_score <= '0;
      best_user  <= '0;
      new_record <= 1'b0;
      for (int i = 0; i < NUM_USERS; i++) score_tbl[i] <= '0;
    end else begin
      new_record <= 1'b0;
      case (state)
        S_IDLE: begin
          if (valid_in) begin
            cur_user <= user_ID;
            state    <= S_LOAD;
          end else if (clear_scores) begin
            for (int i = 0; i < NUM_USERS; i++) score_tbl[i] <= '0;
            best_score <= '0;
            best_user  <= '0;
          end
        end
        S_LOAD: begin
          uhs_q <= stored;
          state <= S_READY;
        end
        S_READY: begin
          if (!valid_in) begin
            state <= S_IDLE;
          end else if (game_over) begin
            cur_score <= score;
            state     <= S_CMP;
          end
        end
        S_CMP: begin
          rec   <= user_valid && (cur_score > stored);
          state <= S_WRITE;
        end
        S_WRITE: begin
          if (rec) begin
            for (int i = 0; i < NUM_USERS; i++) begin
              if (cur_user == 3'(i)) score_tbl[i] <= cur_score;
            end
            uhs_q      <= cur_score;
            new_record <= 1'b1;
            if (cur_score > best_score) begin
              best_score <= cur_score;
              best_user  <= cur_user;
            end
          end
          state <= valid_in ? S_READY : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_high_score_keeper.sv
// tb/tb_high_score_keeper.sv - directed and randomized bench for high_score_keeper
// Expected values come from a plain per-user array plus best-score bookkeeping.
module tb_high_score_keeper;

  localparam int NU = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_in;
  logic [2:0] user_ID;
  logic       game_over;
  logic [7:0] score;
  logic       clear_scores;
  logic [7:0] user_high_score;
  logic [7:0] best_score;
  logic [2:0] best_user;
  logic       new_record;
  logic       busy;

  high_score_keeper #(.NUM_USERS(NU), .SCORE_W(8)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .user_ID(user_ID),
    .game_over(game_over), .score(score), .clear_scores(clear_scores),
    .user_high_score(user_high_score), .best_score(best_score),
    .best_user(best_user), .new_record(new_record), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int ref_tbl [8];
  int ref_best;
  int ref_bu;
  int cur_u;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int ref_read(input int u);
    return (u < NU) ? ref_tbl[u] : 0;
  endfunction

  function automatic void ref_clear();
    for (int i = 0; i < 8; i++) ref_tbl[i] = 0;
    ref_best = 0;
    ref_bu   = 0;
  endfunction

  function automatic bit ref_game(input int u, input int s);
    bit r;
    r = (u < NU) && (s > ref_tbl[u]);
    if (r) begin
      ref_tbl[u] = s;
      if (s > ref_best) begin
        ref_best = s;
        ref_bu   = u;
      end
    end
    return r;
  endfunction

  task automatic check_best(input string tag);
    check({tag, "_best"}, best_score, ref_best);
    check({tag, "_best_user"}, best_user, ref_bu);
  endtask

  task automatic login(input int u);
    valid_in = 1'b1;
    user_ID  = 3'(u);
    cur_u    = u;
    @(posedge clk); #1;
    user_ID = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    check("login_uhs", user_high_score, ref_read(u));
    check("login_busy", busy, 1'b0);
  endtask

  task automatic logout();
    valid_in = 1'b0;
    @(posedge clk); #1;
    check("logout_uhs", user_high_score, 0);
  endtask

  task automatic play(input int s);
    bit r;
    game_over = 1'b1;
    score     = 8'(s);
    @(posedge clk); #1;
    game_over = 1'b0;
    check("busy_cmp", busy, 1'b1);
    check("nr_early", new_record, 1'b0);
    @(posedge clk); #1;
    check("busy_wr", busy, 1'b1);
    @(posedge clk); #1;
    r = ref_game(cur_u, s);
    check("new_record", new_record, r);
    check("play_uhs", user_high_score, ref_read(cur_u));
    check("busy_done", busy, 1'b0);
    check_best("play");
    @(posedge clk); #1;
    check("nr_one_cycle", new_record, 1'b0);
  endtask

  initial begin
    int s;
    rst = 1'b1; valid_in = 1'b0; user_ID = '0; game_over = 1'b0;
    score = '0; clear_scores = 1'b0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_uhs", user_high_score, 0);
    check("rst_nr", new_record, 1'b0);
    check("rst_busy", busy, 1'b0);
    check_best("rst");

    // Record, lower score, tie
    login(2);
    play(8'h37);
    play(8'h20);
    play(8'h37);
    logout();
    login(4);
    play(8'h50);
    logout();
    login(2);

    // Accepted game_over completes across logout; second game_over while busy is dropped
    game_over = 1'b1; score = 8'h60;
    @(posedge clk); #1;
    valid_in = 1'b0; score = 8'h99;
    @(posedge clk); #1;
    game_over = 1'b0;
    check("lo_busy", busy, 1'b1);
    @(posedge clk); #1;
    void'(ref_game(2, 8'h60));
    check("lo_new_record", new_record, 1'b1);
    check("lo_uhs_idle", user_high_score, 0);
    check("lo_busy_done", busy, 1'b0);
    check_best("lo");
    login(2);

    // Invalid user and clear outside S_IDLE
    logout();
    login(6);
    play(8'hFF);
    clear_scores = 1'b1;
    @(posedge clk); #1;
    clear_scores = 1'b0;
    check_best("clr_ignored");
    logout();
    login(4);
    logout();
    clear_scores = 1'b1;
    @(posedge clk); #1;
    clear_scores = 1'b0;
    ref_clear();
    check_best("clr_idle");
    login(2);
    logout();

    // Randomized sessions
    for (int k = 0; k < 30; k++) begin
      login($urandom_range(0, 7));
      for (int g = 0; g < 3; g++) begin
        s = ($urandom_range(0, 3) == 0) ? ref_read(cur_u) : $urandom_range(0, 255);
        play(s);
      end
      logout();
      if ($urandom_range(0, 9) == 0) begin
        clear_scores = 1'b1;
        @(posedge clk); #1;
        clear_scores = 1'b0;
        ref_clear();
        check_best("rnd_clr");
      end
    end

    // Asynchronous reset during S_CMP
    login(1);
    game_over = 1'b1; score = 8'hC0;
    @(posedge clk); #1;
    game_over = 1'b0;
    check("pre_rst_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    ref_clear();
    check("arst_uhs", user_high_score, 0);
    check("arst_busy", busy, 1'b0);
    check("arst_nr", new_record, 1'b0);
    check_best("arst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("arst_nr_after", new_record, 1'b0);
    login(1);
    logout();
    login(4);
    logout();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
